adsr_voice_scheduler: RTL and testbench
=======================================

Name: adsr_voice_scheduler

Overview:
- Time-multiplexes one envelope-step datapath across NUM_VOICES voices.
- Holds per-voice ADSR state and volume registers, and latches note-on/note-off events as pending flags.
- On each sample tick it sweeps all voices, one voice per clock, and streams the updated volumes to the mixer.
- Sits between the MIDI note decoder (events) and the voice mixer (volumes).

Parameters:
NUM_VOICES, 8, number of voices; power of two, 2..64
VIDX_W, 3, voice index width; equals log2(NUM_VOICES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_tick  in  1  one-cycle sample-rate strobe; starts a sweep
i_note_on  in  1  one-cycle strobe: note pressed on voice i_voice
i_note_off  in  1  one-cycle strobe: note released on voice i_voice
i_voice  in  VIDX_W  voice index for note strobes
attack_rate  in  7  attack increment per sweep
decay_rate  in  7  decay decrement per sweep
sustain_value  in  7  sustain level; internal level = {1'b0, sustain_value, 10'b0}
release_rate  in  7  release decrement per sweep
o_vol_valid  out  1  o_volume/o_voice/o_state valid this cycle
o_voice  out  VIDX_W  voice index of the current result
o_volume  out  18  updated voice volume
o_state  out  3  updated voice state
o_busy  out  1  sweep in progress
o_frame_done  out  1  one-cycle pulse after the last voice result
o_overrun  out  1  sticky: i_tick arrived while busy

Behaviour:
- Reset (async, rst=1): all voices state BLANK(0), volume 0, pending flags 0. FSM in IDLE. All outputs 0.
- State encoding: BLANK=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. MAX=18'h1FFFF. SUS={1'b0, sustain_value, 10'b0}.
- FSM IDLE -> SWEEP on i_tick.
  - In SWEEP, cycle k processes voice k, for k = 0..NUM_VOICES-1.
  - After voice NUM_VOICES-1 the FSM returns to IDLE.
  - o_busy=1 throughout SWEEP.
  - A sweep takes NUM_VOICES cycles.
- Per-voice step uses P = pending press and R = pending release, both sampled at step time. Next state, first matching rule wins:
  - BLANK & P -> ATTACK.
  - ATTACK & R -> RELEASE.
  - ATTACK & vol >= MAX -> DECAY.
  - DECAY & R -> RELEASE.
  - DECAY & P -> ATTACK.
  - DECAY & vol < SUS -> SUSTAIN.
  - SUSTAIN & P -> ATTACK.
  - SUSTAIN & R -> RELEASE.
  - RELEASE & P -> ATTACK.
  - RELEASE & vol[17] -> BLANK.
  - Otherwise the state holds.
- Next volume is computed from the old state:
  - ATTACK: min(vol + attack_rate, MAX).
  - DECAY: vol - decay_rate, 18-bit wrap.
  - SUSTAIN: SUS.
  - RELEASE: vol - release_rate, 18-bit wrap. Underflow sets bit17; the next sweep moves the voice to BLANK.
  - BLANK: 0.
- Both P and R flags of the processed voice are cleared at write-back, whether or not they were used.
- Output latency: the result for voice k is registered and presented the cycle after voice k is processed.
  - o_vol_valid=1 for exactly NUM_VOICES consecutive cycles per sweep, o_voice ascending.
  - o_volume is forced to 0 when the stored volume has bit17 set. Stored state and volume are unmodified by this masking.
  - o_frame_done pulses in the cycle after the last valid output.
- Note events are accepted in any cycle, IDLE or SWEEP.
  - i_note_on sets P[i_voice]; i_note_off sets R[i_voice].
  - A same-cycle on+off sets both flags.
  - A repeated event while the flag is already set has no additional effect.
- Event to voice v in the same cycle v is processed: the step does not see it, and the set wins over the clear (flag remains 1 for the next sweep).
- i_tick while o_busy=1 is ignored and sets o_overrun.
  - o_overrun clears only on rst.
  - i_tick in the final SWEEP cycle counts as busy.
- Rate inputs are sampled live at each voice step; they are not latched per sweep.
- rst asserted mid-sweep aborts immediately. After release, no o_vol_valid until the next i_tick.

Test Plan:
- Reset, then 3 ticks with no events -> each sweep gives 8 valid outputs, o_voice 0..7, volume 0, state 0; o_frame_done pulses once per sweep.
- Note-on voice 2, attack_rate=127, repeated ticks -> sweep 1: v2 state 1, vol 0. Sweep n: vol (n-1)*127. Sweep 1034: vol 0x1FFFF. Sweep 1035: state 2, vol 0x1FFFF.
- From DECAY with decay_rate=64, sustain_value=0x40 -> vol drops 64 per sweep until below 0x10000. Next sweep: state 3. Subsequent sweeps: vol 0x10000.
- SUSTAIN, note-off v2, release_rate=127 -> state 4. Vol decrements until bit17 set: o_volume reads 0 that sweep. Next sweep: state 0, vol 0.
- Note-on v5 in the exact cycle v5 is processed -> v5 unchanged this sweep, state 1 on the next sweep. Note-on and note-off same cycle on BLANK v6 -> ATTACK, then RELEASE the sweep after only if R was re-asserted (flags cleared).
- Tick asserted during a sweep -> no restart, o_overrun=1 until rst. Rst mid-sweep -> outputs 0 immediately, all voices BLANK.

Source files
------------

// File: rtl/adsr_voice_scheduler.sv
// adsr_voice_scheduler
// Shares one ADSR envelope-step datapath across NUM_VOICES voices. Note-on and
// note-off strobes are latched as pending flags per voice. Each i_tick starts
// a sweep that steps one voice per clock and streams the updated volume and
// state to the mixer one cycle later.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_tick                   sample strobe, starts a sweep when idle
//   i_note_on / i_note_off   event strobes for voice i_voice
//   attack_rate, decay_rate, sustain_value, release_rate   live envelope controls
//   o_vol_valid, o_voice, o_volume, o_state                per-voice result stream
//   o_busy                   sweep in progress
//   o_frame_done             pulse one cycle after the last result of a sweep
//   o_overrun                sticky flag: i_tick seen while busy
module adsr_voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int VIDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_note_on,
  input  logic              i_note_off,
  input  logic [VIDX_W-1:0] i_voice,
  input  logic [6:0]        attack_rate,
  input  logic [6:0]        decay_rate,
  input  logic [6:0]        sustain_value,
  input  logic [6:0]        release_rate,
  output logic              o_vol_valid,
  output logic [VIDX_W-1:0] o_voice,
  output logic [17:0]       o_volume,
  output logic [2:0]        o_state,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overrun
);

  typedef enum logic [2:0] {
    BLANK   = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } vstate_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_t;

  localparam logic [17:0]       VOL_MAX = 18'h1FFFF;
  localparam logic [VIDX_W-1:0] LAST_V  = VIDX_W'(NUM_VOICES - 1);

  fsm_t              fsm_r;
  logic [VIDX_W-1:0] k_r;
  logic              done_pend_r;
  vstate_t           state_mem [NUM_VOICES];
  logic [17:0]       vol_mem   [NUM_VOICES];
  logic [NUM_VOICES-1:0] press_r;
  logic [NUM_VOICES-1:0] rel_r;

  vstate_t               cur_state_s;
  logic [17:0]           cur_vol_s;
  logic                  p_s;
  logic                  r_s;
  logic [17:0]           sus_s;
  logic [18:0]           sum_s;
  vstate_t               next_state_s;
  logic [17:0]           next_vol_s;
  logic [NUM_VOICES-1:0] on_mask_s;
  logic [NUM_VOICES-1:0] off_mask_s;
  logic [NUM_VOICES-1:0] clr_mask_s;

  // Envelope step for the voice selected by the sweep counter
  always_comb begin
    cur_state_s  = state_mem[k_r];
    cur_vol_s    = vol_mem[k_r];
    p_s          = press_r[k_r];
    r_s          = rel_r[k_r];
    sus_s        = {1'b0, sustain_value, 10'd0};
    sum_s        = {1'b0, cur_vol_s} + {12'd0, attack_rate};
    next_state_s = cur_state_s;
    next_vol_s   = 18'd0;
    case (cur_state_s)
      BLANK: begin
        if (p_s) next_state_s = ATTACK;
        else     next_state_s = BLANK;
        next_vol_s = 18'd0;
      end
      ATTACK: begin
        if (r_s)                     next_state_s = RELEASE;
        else if (cur_vol_s >= VOL_MAX) next_state_s = DECAY;
        else                         next_state_s = ATTACK;
        // Saturate at full scale rather than wrapping into bit 17
        if (sum_s > {1'b0, VOL_MAX}) next_vol_s = VOL_MAX;
        else                         next_vol_s = sum_s[17:0];
      end
      DECAY: begin
        if (r_s)                  next_state_s = RELEASE;
        else if (p_s)             next_state_s = ATTACK;
        else if (cur_vol_s < sus_s) next_state_s = SUSTAIN;
        else                      next_state_s = DECAY;
        next_vol_s = cur_vol_s - {11'd0, decay_rate};
      end
      SUSTAIN: begin
        if (p_s)      next_state_s = ATTACK;
        else if (r_s) next_state_s = RELEASE;
        else          next_state_s = SUSTAIN;
        next_vol_s = sus_s;
      end
      RELEASE: begin
        // Underflow below zero wraps and sets bit 17; that voice retires next sweep
        if (p_s)               next_state_s = ATTACK;
        else if (cur_vol_s[17]) next_state_s = BLANK;
        else                   next_state_s = RELEASE;
        next_vol_s = cur_vol_s - {11'd0, release_rate};
      end
      default: begin
        next_state_s = BLANK;
        next_vol_s   = 18'd0;
      end
    endcase
  end

  // Event set masks and the write-back clear mask for the voice being stepped
  always_comb begin
    on_mask_s  = '0;
    off_mask_s = '0;
    clr_mask_s = '0;
    if (i_note_on) on_mask_s[i_voice] = 1'b1;
    else           on_mask_s = '0;
    if (i_note_off) off_mask_s[i_voice] = 1'b1;
    else            off_mask_s = '0;
    if (fsm_r == SWEEP) clr_mask_s[k_r] = 1'b1;
    else                clr_mask_s = '0;
  end

  // Pending flags: a new event in the same cycle as write-back survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_r <= '0;
      rel_r   <= '0;
    end else begin
      press_r <= (press_r & ~clr_mask_s) | on_mask_s;
      rel_r   <= (rel_r & ~clr_mask_s) | off_mask_s;
    end
  end

  // Sweep FSM, per-voice state write-back and registered result stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r        <= IDLE;
      k_r          <= '0;
      done_pend_r  <= 1'b0;
      o_vol_valid  <= 1'b0;
      o_voice      <= '0;
      o_volume     <= 18'd0;
      o_state      <= 3'd0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_mem[v] <= BLANK;
        vol_mem[v]   <= 18'd0;
      end
    end else begin
      o_vol_valid  <= 1'b0;
      o_frame_done <= done_pend_r;
      done_pend_r  <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (i_tick) begin
            fsm_r  <= SWEEP;
            k_r    <= '0;
            o_busy <= 1'b1;
          end else begin
            fsm_r  <= IDLE;
          end
        end
        SWEEP: begin
          if (i_tick) o_overrun <= 1'b1;
          else        o_overrun <= o_overrun;
          state_mem[k_r] <= next_state_s;
          vol_mem[k_r]   <= next_vol_s;
          o_vol_valid    <= 1'b1;
          o_voice        <= k_r;
          // Underflowed volumes read as silence; the stored value is kept
          o_volume       <= next_vol_s[17] ? 18'd0 : next_vol_s;
          o_state        <= next_state_s;
          if (k_r == LAST_V) begin
            fsm_r       <= IDLE;
            o_busy      <= 1'b0;
            done_pend_r <= 1'b1;
          end else begin
            k_r <= k_r + VIDX_W'(1);
          end
        end
        default: begin
          fsm_r  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adsr_voice_scheduler.sv
// Directed testbench for adsr_voice_scheduler (NUM_VOICES=8).
module tb_adsr_voice_scheduler;

  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_tick, i_note_on, i_note_off;
  logic [2:0]  i_voice;
  logic [6:0]  attack_rate, decay_rate, sustain_value, release_rate;
  logic        o_vol_valid;
  logic [2:0]  o_voice;
  logic [17:0] o_volume;
  logic [2:0]  o_state;
  logic        o_busy, o_frame_done, o_overrun;

  int errors = 0;
  int checks = 0;

  logic [17:0] got_vol [NV];
  logic [2:0]  got_st  [NV];

  adsr_voice_scheduler #(.NUM_VOICES(8), .VIDX_W(3)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_note_on(i_note_on),
    .i_note_off(i_note_off), .i_voice(i_voice), .attack_rate(attack_rate),
    .decay_rate(decay_rate), .sustain_value(sustain_value),
    .release_rate(release_rate), .o_vol_valid(o_vol_valid), .o_voice(o_voice),
    .o_volume(o_volume), .o_state(o_state), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // One sweep: tick, optional event injected while voice ev_slot is stepped,
  // optional extra tick at cycle tick_slot; collects all 8 results.
  task automatic run_sweep(input int ev_slot, input logic ev_on, input logic ev_off,
                           input logic [2:0] ev_voice, input int tick_slot);
    @(negedge clk);
    i_tick = 1'b1;
    for (int c = 1; c <= NV + 2; c++) begin
      @(negedge clk);
      i_tick     = (c == tick_slot);
      i_note_on  = (c == ev_slot + 1) && ev_on;
      i_note_off = (c == ev_slot + 1) && ev_off;
      i_voice    = ev_voice;
      checks++;
      if (c >= 2 && c <= NV + 1) begin
        if (o_vol_valid !== 1'b1 || o_voice !== 3'(c - 2)) begin
          errors++;
          $display("FAIL sweep_out c=%0d: valid=%b voice=%0d, required valid=1 voice=%0d", c, o_vol_valid, o_voice, c - 2);
        end
        got_vol[c-2] = o_volume;
        got_st[c-2]  = o_state;
      end else if (o_vol_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_idle c=%0d: valid=%b, required 0", c, o_vol_valid);
      end
      checks++;
      if (o_frame_done !== (c == NV + 2)) begin
        errors++;
        $display("FAIL frame_done c=%0d: got %b, required %b", c, o_frame_done, c == NV + 2);
      end
      if (c == 1 || c == NV + 1) begin
        checks++;
        if (o_busy !== (c == 1)) begin
          errors++;
          $display("FAIL busy c=%0d: got %b, required %b", c, o_busy, c == 1);
        end
      end
    end
    i_tick = 1'b0; i_note_on = 1'b0; i_note_off = 1'b0;
  endtask

  task automatic note(input logic on, input logic off, input logic [2:0] v);
    @(negedge clk);
    i_note_on = on; i_note_off = off; i_voice = v;
    @(negedge clk);
    i_note_on = 1'b0; i_note_off = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({o_vol_valid, o_voice, o_volume, o_state, o_busy, o_frame_done, o_overrun} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {o_vol_valid, o_voice, o_volume, o_state, o_busy, o_frame_done, o_overrun});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_sweeps();
    for (int s = 0; s < 3; s++) begin
      run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
      for (int v = 0; v < NV; v++) begin
        checks++;
        if (got_vol[v] !== 18'd0 || got_st[v] !== 3'd0) begin
          errors++;
          $display("FAIL idle_voice s=%0d v=%0d: vol=%h st=%0d, required 0/0", s, v, got_vol[v], got_st[v]);
        end
      end
    end
  endtask

  task automatic test_attack();
    logic [17:0] ev;
    logic [2:0]  es;
    note(1'b1, 1'b0, 3'd2);
    for (int n = 1; n <= 1035; n++) begin
      run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
      if (n <= 1034) begin
        es = 3'd1;
        ev = ((n - 1) * 127 > 131071) ? 18'h1FFFF : 18'((n - 1) * 127);
      end else begin
        es = 3'd2;
        ev = 18'h1FFFF;
      end
      checks++;
      if (got_st[2] !== es || got_vol[2] !== ev) begin
        errors++;
        $display("FAIL attack n=%0d: st=%0d vol=%h, required st=%0d vol=%h", n, got_st[2], got_vol[2], es, ev);
      end
    end
    checks++;
    if (got_st[0] !== 3'd0 || got_vol[0] !== 18'd0) begin
      errors++;
      $display("FAIL attack_other: v0 st=%0d vol=%h, required 0/0", got_st[0], got_vol[0]);
    end
  endtask

  task automatic test_decay();
    logic [17:0] ev;
    logic [2:0]  es;
    for (int d = 1; d <= 1027; d++) begin
      run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
      if (d <= 1024)      begin es = 3'd2; ev = 18'(131071 - 64 * d); end
      else if (d == 1025) begin es = 3'd3; ev = 18'd65471; end
      else                begin es = 3'd3; ev = 18'h10000; end
      checks++;
      if (got_st[2] !== es || got_vol[2] !== ev) begin
        errors++;
        $display("FAIL decay d=%0d: st=%0d vol=%h, required st=%0d vol=%h", d, got_st[2], got_vol[2], es, ev);
      end
    end
  endtask

  task automatic test_release();
    logic [17:0] ev;
    logic [2:0]  es;
    note(1'b0, 1'b1, 3'd2);
    for (int r = 1; r <= 520; r++) begin
      run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
      if (r == 1)        begin es = 3'd4; ev = 18'h10000; end
      else if (r <= 517) begin es = 3'd4; ev = 18'(65536 - 127 * (r - 1)); end
      else if (r == 518) begin es = 3'd4; ev = 18'd0; end
      else               begin es = 3'd0; ev = 18'd0; end
      checks++;
      if (got_st[2] !== es || got_vol[2] !== ev) begin
        errors++;
        $display("FAIL release r=%0d: st=%0d vol=%h, required st=%0d vol=%h", r, got_st[2], got_vol[2], es, ev);
      end
    end
  endtask

  task automatic test_event_timing();
    run_sweep(5, 1'b1, 1'b0, 3'd5, 0);
    checks++;
    if (got_st[5] !== 3'd0) begin
      errors++;
      $display("FAIL same_cycle_on: v5 st=%0d, required 0", got_st[5]);
    end
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
    checks++;
    if (got_st[5] !== 3'd1 || got_vol[5] !== 18'd0) begin
      errors++;
      $display("FAIL deferred_on: v5 st=%0d vol=%h, required 1/0", got_st[5], got_vol[5]);
    end
    note(1'b1, 1'b1, 3'd6);
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
    checks++;
    if (got_st[6] !== 3'd1 || got_vol[6] !== 18'd0 || got_vol[5] !== 18'd127) begin
      errors++;
      $display("FAIL on_off_blank: v6 st=%0d vol=%h v5 vol=%h, required 1/0 and 127", got_st[6], got_vol[6], got_vol[5]);
    end
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
    checks++;
    if (got_st[6] !== 3'd1 || got_vol[6] !== 18'd127) begin
      errors++;
      $display("FAIL flags_cleared: v6 st=%0d vol=%h, required 1/7f", got_st[6], got_vol[6]);
    end
    note(1'b0, 1'b1, 3'd6);
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
    checks++;
    if (got_st[6] !== 3'd4 || got_vol[6] !== 18'd254) begin
      errors++;
      $display("FAIL reassert_off: v6 st=%0d vol=%h, required 4/fe", got_st[6], got_vol[6]);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_init: got %b, required 0", o_overrun);
    end
    // Tick in the last sweep cycle is a busy tick and must not restart
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_vol_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b1) begin
        errors++;
        $display("FAIL overrun_norestart i=%0d: valid=%b busy=%b ovr=%b, required 0/0/1", i, o_vol_valid, o_busy, o_overrun);
      end
    end
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", o_overrun);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({o_vol_valid, o_voice, o_volume, o_state, o_busy, o_frame_done, o_overrun} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, required 0", {o_vol_valid, o_voice, o_volume, o_state, o_busy, o_frame_done, o_overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_vol_valid !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet i=%0d: valid=%b busy=%b, required 0/0", i, o_vol_valid, o_busy);
      end
    end
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 0);
    for (int v = 0; v < NV; v++) begin
      checks++;
      if (got_st[v] !== 3'd0 || got_vol[v] !== 18'd0) begin
        errors++;
        $display("FAIL post_reset_blank v=%0d: st=%0d vol=%h, required 0/0", v, got_st[v], got_vol[v]);
      end
    end
    // Mid-sweep tick after the reset sets the flag again
    run_sweep(-1, 1'b0, 1'b0, 3'd0, 3);
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_mid: got %b, required 1", o_overrun);
    end
  endtask

  initial begin
    i_tick = 1'b0; i_note_on = 1'b0; i_note_off = 1'b0; i_voice = 3'd0;
    attack_rate = 7'd127; decay_rate = 7'd64; sustain_value = 7'h40; release_rate = 7'd127;
    test_reset();
    test_idle_sweeps();
    test_attack();
    test_decay();
    test_release();
    test_event_timing();
    test_overrun();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
